// File: rtl/efx_isg_cam_dma_packer_pkg.sv
// Shared types and widths for the camera DMA packer: the capture FSM states
// and the pixel / DMA word geometry.
package efx_isg_cam_dma_pkg;

  localparam int PIXEL_W         = 32;
  localparam int PIXELS_PER_WORD = 2;
  localparam int WORD_W          = PIXEL_W * PIXELS_PER_WORD;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DRAIN
  } state_e;

endpackage

// File: rtl/efx_isg_cam_dma_packer_if.sv
// Camera DMA write channel: AXI-stream style valid/ready with a wlast marker.
interface efx_isg_cam_dma_packer_if;
  import efx_isg_cam_dma_pkg::*;

  logic              wvalid;
  logic              wready;
  logic              wlast;
  logic [WORD_W-1:0] wdata;

  modport master (output wvalid, output wlast, output wdata, input wready);
  modport slave  (input wvalid, input wlast, input wdata, output wready);

endinterface

// File: rtl/efx_isg_cam_dma_packer_fifo.sv
// First-word-fall-through FIFO of packed DMA words; writes while full and
// reads while empty are ignored, so the caller owns drop accounting.
module efx_isg_cam_dma_fifo
  import efx_isg_cam_dma_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           wrEn_i,
  input  logic [WORD_W-1:0]              wrData_i,
  input  logic                           rdEn_i,
  output logic [WORD_W-1:0]              rdData_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wrPtr_q, rdPtr_q;
  logic [CW-1:0]     count_q;
  logic              wrOk, rdOk;

  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign wrOk     = wrEn_i && !full_o;
  assign rdOk     = rdEn_i && !empty_o;
  assign rdData_o = mem[rdPtr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (wrOk) wrPtr_q <= wrPtr_q + 1'b1;
      if (rdOk) rdPtr_q <= rdPtr_q + 1'b1;
      case ({wrOk, rdOk})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wrOk) mem[wrPtr_q] <= wrData_i;
  end

endmodule

// File: rtl/efx_isg_cam_dma_packer.sv
// Packs a framed 32-bit pixel stream two-per-word into a FIFO and drains it
// to the camera DMA write channel in wlast-delimited bursts.
module efx_isg_cam_dma_packer
  import efx_isg_cam_dma_pkg::*;
#(
  parameter int FRAME_WIDTH  = 1920,
  parameter int FRAME_HEIGHT = 1080,
  parameter int BURST_LEN    = 256,
  parameter int FIFO_DEPTH   = 512
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_enable,
  input  logic                   i_vsync,
  input  logic                   i_pixel_valid,
  input  logic [PIXEL_W-1:0]     i_pixel_data,
  input  logic                   i_status_clr,
  efx_isg_cam_dma_packer_if.master cam_dma,
  output logic                   o_frame_done,
  output logic [15:0]            o_frame_count,
  output logic                   o_overflow,
  output logic                   o_short_frame,
  output logic                   o_busy
);

  localparam int TOTAL_PIX = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int PIX_W     = $clog2(TOTAL_PIX + 1);
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int BURST_W   = $clog2(BURST_LEN);

  state_e              state_q, state_d;
  logic                startFrame, earlyEnd, capturing, accept, lastPix;
  logic [PIX_W-1:0]    pixCnt_q, pixCnt_d;
  logic [PIXEL_W-1:0]  evenPix_q, evenPix_d;
  logic                pending_q, pending_d;
  logic                push;
  logic [WORD_W-1:0]   pushData;
  logic                fifoFull, fifoEmpty;
  logic [CNT_W-1:0]    fifoCount;
  logic [WORD_W-1:0]   fifoData;
  logic                pop, wlast, finalPop, drainDone;
  logic [BURST_W-1:0]  burstCnt_q, burstCnt_d;
  logic [15:0]         frameCnt_q, frameCnt_d;
  logic                frameDone_q;
  logic                overflow_q, overflow_d;
  logic                shortFrame_q, shortFrame_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_enable) state_d = ARMED;
      ARMED:   if (i_vsync) state_d = !i_enable ? IDLE : (lastPix ? DRAIN : CAPTURE);
      CAPTURE: if (i_vsync || lastPix) state_d = DRAIN;
      DRAIN:   if (drainDone) state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  // A vsync inside CAPTURE ends the frame; it never doubles as a frame start.
  always_comb begin
    startFrame = 1'b0;
    earlyEnd   = 1'b0;
    capturing  = 1'b0;
    o_busy     = 1'b0;
    case (state_q)
      ARMED:   startFrame = i_vsync && i_enable;
      CAPTURE: begin
        earlyEnd  = i_vsync;
        capturing = !i_vsync;
        o_busy    = 1'b1;
      end
      DRAIN:   o_busy = 1'b1;
      default: ;
    endcase
  end

  assign accept  = i_pixel_valid && (startFrame || capturing);
  assign lastPix = accept && (startFrame ? (TOTAL_PIX == 1)
                                         : (pixCnt_q == PIX_W'(TOTAL_PIX - 1)));

  always_comb begin
    pixCnt_d  = startFrame ? '0 : pixCnt_q;
    evenPix_d = evenPix_q;
    pending_d = startFrame ? 1'b0 : pending_q;
    push      = 1'b0;
    pushData  = '0;
    if (accept) begin
      pixCnt_d = pixCnt_d + 1'b1;
      if (pending_d) begin
        push      = 1'b1;
        pushData  = {i_pixel_data, evenPix_q};
        pending_d = 1'b0;
      end else if (lastPix) begin
        push     = 1'b1;
        pushData = {{PIXEL_W{1'b0}}, i_pixel_data};
      end else begin
        evenPix_d = i_pixel_data;
        pending_d = 1'b1;
      end
    end else if (earlyEnd && pending_q) begin
      push      = 1'b1;
      pushData  = {{PIXEL_W{1'b0}}, evenPix_q};
      pending_d = 1'b0;
    end
  end

  efx_isg_cam_dma_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .wrEn_i   (push),
    .wrData_i (pushData),
    .rdEn_i   (pop),
    .rdData_o (fifoData),
    .full_o   (fifoFull),
    .empty_o  (fifoEmpty),
    .count_o  (fifoCount)
  );

  // In DRAIN nothing more can be pushed, so a single remaining word is the frame's last.
  assign pop       = cam_dma.wvalid && cam_dma.wready;
  assign wlast     = !fifoEmpty &&
                     ((burstCnt_q == BURST_W'(BURST_LEN - 1)) ||
                      ((state_q == DRAIN) && (fifoCount == CNT_W'(1)) && !push));
  assign finalPop  = (state_q == DRAIN) && pop && (fifoCount == CNT_W'(1));
  assign drainDone = (state_q == DRAIN) && (fifoEmpty || finalPop);

  assign cam_dma.wvalid = !fifoEmpty;
  assign cam_dma.wlast  = wlast;
  assign cam_dma.wdata  = fifoEmpty ? '0 : fifoData;

  always_comb begin
    burstCnt_d = burstCnt_q;
    if (startFrame)  burstCnt_d = '0;
    else if (pop)    burstCnt_d = wlast ? '0 : burstCnt_q + 1'b1;
  end

  assign frameCnt_d   = frameCnt_q + {15'd0, drainDone};
  assign overflow_d   = (push && fifoFull) || (overflow_q && !i_status_clr);
  assign shortFrame_d = earlyEnd || (shortFrame_q && !i_status_clr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pixCnt_q     <= '0;
      evenPix_q    <= '0;
      pending_q    <= 1'b0;
      burstCnt_q   <= '0;
      frameCnt_q   <= '0;
      frameDone_q  <= 1'b0;
      overflow_q   <= 1'b0;
      shortFrame_q <= 1'b0;
    end else begin
      pixCnt_q     <= pixCnt_d;
      evenPix_q    <= evenPix_d;
      pending_q    <= pending_d;
      burstCnt_q   <= burstCnt_d;
      frameCnt_q   <= frameCnt_d;
      frameDone_q  <= drainDone;
      overflow_q   <= overflow_d;
      shortFrame_q <= shortFrame_d;
    end
  end

  assign o_frame_done  = frameDone_q;
  assign o_frame_count = frameCnt_q;
  assign o_overflow    = overflow_q;
  assign o_short_frame = shortFrame_q;

endmodule

// File: tb/tb_efx_isg_cam_dma_packer.sv
// Bench for the camera DMA packer: three small configurations share one pixel
// source; emitted words are compared against a table of hand-computed words.
module tb_efx_isg_cam_dma_packer;
  import efx_isg_cam_dma_pkg::*;

  typedef struct {
    string       name;
    int          grp;
    int          dut;
    logic [31:0] pxLo;
    logic [31:0] pxHi;
    logic        last;
  } vec_t;

  typedef struct {
    int          dut;
    logic        last;
    logic [63:0] data;
  } cap_t;

  logic        clk = 1'b0;
  logic        rstn, enA, enB, enC, vsync, pixValid, statusClr;
  logic [31:0] pixData;
  logic        readyA, readyB, readyC, randA;

  logic        wvS [3];
  logic        wrS [3];
  logic        wlS [3];
  logic [63:0] wdS [3];
  logic        doneS [3];
  logic [15:0] cntS [3];
  logic        ovS [3];
  logic        shS [3];
  logic        busyS [3];

  int          checks = 0;
  int          failures = 0;
  int          doneCnt [3] = '{0, 0, 0};
  logic        prevStall [3] = '{1'b0, 1'b0, 1'b0};
  logic [63:0] prevData [3];
  logic        prevLast [3];
  vec_t        vecs [$];
  cap_t        cap [$];

  always #5 clk = ~clk;

  efx_isg_cam_dma_packer_if dmaA ();
  efx_isg_cam_dma_packer_if dmaB ();
  efx_isg_cam_dma_packer_if dmaC ();

  assign dmaA.wready = readyA;
  assign dmaB.wready = readyB;
  assign dmaC.wready = readyC;
  assign wvS[0] = dmaA.wvalid; assign wrS[0] = dmaA.wready; assign wlS[0] = dmaA.wlast; assign wdS[0] = dmaA.wdata;
  assign wvS[1] = dmaB.wvalid; assign wrS[1] = dmaB.wready; assign wlS[1] = dmaB.wlast; assign wdS[1] = dmaB.wdata;
  assign wvS[2] = dmaC.wvalid; assign wrS[2] = dmaC.wready; assign wlS[2] = dmaC.wlast; assign wdS[2] = dmaC.wdata;

  efx_isg_cam_dma_packer #(.FRAME_WIDTH(8), .FRAME_HEIGHT(2), .BURST_LEN(4), .FIFO_DEPTH(16)) dutA (
    .clk(clk), .rstn(rstn), .i_enable(enA), .i_vsync(vsync), .i_pixel_valid(pixValid),
    .i_pixel_data(pixData), .i_status_clr(statusClr), .cam_dma(dmaA),
    .o_frame_done(doneS[0]), .o_frame_count(cntS[0]), .o_overflow(ovS[0]),
    .o_short_frame(shS[0]), .o_busy(busyS[0]));

  efx_isg_cam_dma_packer #(.FRAME_WIDTH(3), .FRAME_HEIGHT(3), .BURST_LEN(4), .FIFO_DEPTH(16)) dutB (
    .clk(clk), .rstn(rstn), .i_enable(enB), .i_vsync(vsync), .i_pixel_valid(pixValid),
    .i_pixel_data(pixData), .i_status_clr(statusClr), .cam_dma(dmaB),
    .o_frame_done(doneS[1]), .o_frame_count(cntS[1]), .o_overflow(ovS[1]),
    .o_short_frame(shS[1]), .o_busy(busyS[1]));

  efx_isg_cam_dma_packer #(.FRAME_WIDTH(8), .FRAME_HEIGHT(2), .BURST_LEN(4), .FIFO_DEPTH(4)) dutC (
    .clk(clk), .rstn(rstn), .i_enable(enC), .i_vsync(vsync), .i_pixel_valid(pixValid),
    .i_pixel_data(pixData), .i_status_clr(statusClr), .cam_dma(dmaC),
    .o_frame_done(doneS[2]), .o_frame_count(cntS[2]), .o_overflow(ovS[2]),
    .o_short_frame(shS[2]), .o_busy(busyS[2]));

  // Record handshakes, count done pulses and require wdata/wlast to hold across stalls.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (prevStall[d] && wvS[d]) begin
        checks++;
        if (wdS[d] !== prevData[d] || wlS[d] !== prevLast[d]) begin
          failures++;
          $display("[TB] FAIL stall_hold_dut%0d: got data=%h last=%b, required data=%h last=%b",
                   d, wdS[d], wlS[d], prevData[d], prevLast[d]);
        end
      end
      prevStall[d] = wvS[d] && !wrS[d];
      prevData[d]  = wdS[d];
      prevLast[d]  = wlS[d];
      if (wvS[d] && wrS[d]) cap.push_back('{d, wlS[d], wdS[d]});
      if (doneS[d]) doneCnt[d]++;
    end
  end

  function automatic logic [31:0] px(input int seed, input int i);
    return {8'hA5, seed[7:0], i[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (randA) readyA = 1'($urandom_range(0, 1));
  endtask

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic addWord(input string name, input int grp, input int dut,
                         input logic [31:0] lo, input logic [31:0] hi, input logic last);
    vecs.push_back('{name, grp, dut, lo, hi, last});
  endtask

  // Drives one frame starting with vsync on pixel 0; optionally ends it early with a bare vsync.
  task automatic applyStimulus(input int seed, input int nPix, input bit earlyVsync);
    for (int i = 0; i < nPix; i++) begin
      vsync    = (i == 0);
      pixValid = 1'b1;
      pixData  = px(seed, i);
      tick();
    end
    vsync    = 1'b0;
    pixValid = 1'b0;
    pixData  = '0;
    if (earlyVsync) begin
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
    end
  endtask

  task automatic waitDone(input string name, input int d, input int target, input int budget);
    int n = 0;
    while (doneCnt[d] < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput(name, 64'(doneCnt[d]), 64'(target));
  endtask

  task automatic checkWords(input int grp);
    int ci = 0;
    int nExp = 0;
    int nGot = 0;
    int dut = -1;
    foreach (vecs[i]) begin
      if (vecs[i].grp == grp) begin
        dut = vecs[i].dut;
        nExp++;
        while (ci < cap.size() && cap[ci].dut != dut) ci++;
        if (ci >= cap.size()) begin
          checks++;
          failures++;
          $display("[TB] FAIL %s: got no word, required data=%h", vecs[i].name, {vecs[i].pxHi, vecs[i].pxLo});
        end else begin
          checkOutput({vecs[i].name, "_data"}, cap[ci].data, {vecs[i].pxHi, vecs[i].pxLo});
          checkOutput({vecs[i].name, "_last"}, 64'(cap[ci].last), 64'(vecs[i].last));
          ci++;
        end
      end
    end
    foreach (cap[i]) if (cap[i].dut == dut) nGot++;
    checkOutput($sformatf("g%0d_word_count", grp), 64'(nGot), 64'(nExp));
  endtask

  initial begin
    int base;
    rstn = 1'b0; enA = 1'b0; enB = 1'b0; enC = 1'b0;
    vsync = 1'b0; pixValid = 1'b0; pixData = '0; statusClr = 1'b0;
    readyA = 1'b1; readyB = 1'b1; readyC = 1'b1; randA = 1'b0;

    for (int w = 0; w < 8; w++) addWord($sformatf("t1_w%0d", w), 1, 0, px(1, 2*w), px(1, 2*w+1), w == 3 || w == 7);
    for (int w = 0; w < 4; w++) addWord($sformatf("t2_w%0d", w), 2, 1, px(2, 2*w), px(2, 2*w+1), w == 3);
    addWord("t2_w4", 2, 1, px(2, 8), 32'h0, 1'b1);
    for (int w = 0; w < 8; w++) addWord($sformatf("t3_w%0d", w), 3, 0, px(3, 2*w), px(3, 2*w+1), w == 3 || w == 7);
    for (int w = 0; w < 4; w++) addWord($sformatf("t4_w%0d", w), 4, 2, px(4, 2*w), px(4, 2*w+1), w == 3);
    addWord("t5_w0", 5, 0, px(5, 0), px(5, 1), 1'b0);
    addWord("t5_w1", 5, 0, px(5, 2), px(5, 3), 1'b0);
    addWord("t5_w2", 5, 0, px(5, 4), 32'h0, 1'b1);
    for (int w = 0; w < 8; w++) addWord($sformatf("t5b_w%0d", w), 6, 0, px(6, 2*w), px(6, 2*w+1), w == 3 || w == 7);
    addWord("t6_w0", 7, 0, px(7, 0), px(7, 1), 1'b0);
    addWord("t6_w1", 7, 0, px(7, 2), px(7, 3), 1'b0);
    for (int w = 0; w < 8; w++) addWord($sformatf("t6b_w%0d", w), 8, 0, px(8, 2*w), px(8, 2*w+1), w == 3 || w == 7);

    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset_wvalid%0d", d), 64'(wvS[d]), 64'd0);
      checkOutput($sformatf("reset_wlast%0d", d), 64'(wlS[d]), 64'd0);
      checkOutput($sformatf("reset_wdata%0d", d), wdS[d], 64'd0);
      checkOutput($sformatf("reset_done%0d", d), 64'(doneS[d]), 64'd0);
      checkOutput($sformatf("reset_count%0d", d), 64'(cntS[d]), 64'd0);
      checkOutput($sformatf("reset_flags%0d", d), 64'({ovS[d], shS[d], busyS[d]}), 64'd0);
    end
    rstn = 1'b1;
    tick();

    $display("[TB] test 1: 8x2 frame, wready high");
    enA = 1'b1;
    repeat (2) tick();
    cap.delete();
    applyStimulus(1, 16, 1'b0);
    waitDone("t1_done", 0, 1, 200);
    repeat (3) tick();
    checkWords(1);
    checkOutput("t1_done_once", 64'(doneCnt[0]), 64'd1);
    checkOutput("t1_frame_count", 64'(cntS[0]), 64'd1);
    checkOutput("t1_flags", 64'({ovS[0], shS[0]}), 64'd0);

    $display("[TB] test 3: 8x2 frame, random wready");
    cap.delete();
    randA = 1'b1;
    applyStimulus(3, 16, 1'b0);
    waitDone("t3_done", 0, 2, 400);
    randA = 1'b0;
    readyA = 1'b1;
    repeat (3) tick();
    checkWords(3);
    checkOutput("t3_frame_count", 64'(cntS[0]), 64'd2);
    checkOutput("t3_overflow", 64'(ovS[0]), 64'd0);

    $display("[TB] test 2: 3x3 frame, odd pixel count");
    enA = 1'b0;
    enB = 1'b1;
    repeat (2) tick();
    cap.delete();
    applyStimulus(2, 9, 1'b0);
    waitDone("t2_done", 1, 1, 200);
    repeat (3) tick();
    checkWords(2);
    checkOutput("t2_short", 64'(shS[1]), 64'd0);
    checkOutput("t2_frame_count", 64'(cntS[1]), 64'd1);

    $display("[TB] test 4: depth-4 FIFO overflow");
    enB = 1'b0;
    enC = 1'b1;
    readyC = 1'b0;
    repeat (2) tick();
    cap.delete();
    applyStimulus(4, 16, 1'b0);
    repeat (3) tick();
    checkOutput("t4_overflow_set", 64'(ovS[2]), 64'd1);
    readyC = 1'b1;
    waitDone("t4_done", 2, 1, 200);
    repeat (3) tick();
    checkWords(4);
    checkOutput("t4_overflow_sticky", 64'(ovS[2]), 64'd1);
    statusClr = 1'b1;
    tick();
    statusClr = 1'b0;
    tick();
    checkOutput("t4_overflow_cleared", 64'(ovS[2]), 64'd0);

    $display("[TB] test 5: early vsync after 5 pixels");
    enC = 1'b0;
    enA = 1'b1;
    repeat (2) tick();
    cap.delete();
    applyStimulus(5, 5, 1'b1);
    waitDone("t5_drain", 0, 3, 200);
    repeat (3) tick();
    checkWords(5);
    checkOutput("t5_short_set", 64'(shS[0]), 64'd1);
    cap.delete();
    applyStimulus(6, 16, 1'b0);
    waitDone("t5b_done", 0, 4, 200);
    repeat (3) tick();
    checkWords(6);
    checkOutput("t5b_short_sticky", 64'(shS[0]), 64'd1);

    $display("[TB] test 6: reset mid-burst");
    readyA = 1'b0;
    cap.delete();
    applyStimulus(7, 16, 1'b0);
    repeat (3) tick();
    readyA = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    readyA = 1'b0;
    #1;
    checkOutput("t6_wvalid_drop", 64'(wvS[0]), 64'd0);
    checkOutput("t6_wlast_drop", 64'(wlS[0]), 64'd0);
    checkOutput("t6_count_clr", 64'(cntS[0]), 64'd0);
    checkOutput("t6_flags_clr", 64'({ovS[0], shS[0], busyS[0]}), 64'd0);
    tick();
    checkWords(7);
    rstn = 1'b1;
    readyA = 1'b1;
    repeat (2) tick();
    cap.delete();
    base = doneCnt[0];
    applyStimulus(8, 16, 1'b0);
    waitDone("t6b_done", 0, base + 1, 200);
    repeat (3) tick();
    checkWords(8);
    checkOutput("t6b_frame_count", 64'(cntS[0]), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
